// File: rtl/mcp9808_scheduler.sv
// Schedules periodic temperature samples, host configuration writes and
// shutdown/wake requests onto a single-operation MCP9808 sensor interface.
module mcp9808_scheduler #(
   parameter int PERIOD  = 1000000,
   parameter int TIMEOUT = 4000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        sleep,
   input  logic        cfg_req,
   input  logic [1:0]  cfg_kind,
   input  logic [10:0] cfg_data,
   output logic        cfg_ack,
   input  logic        err_clr,
   input  logic        if_ready,
   input  logic [11:0] if_tempVal,
   input  logic        if_tempSign,
   output logic        if_update,
   output logic        if_shutdown,
   output logic [1:0]  if_tempWrite,
   output logic [10:0] if_tempInput,
   output logic [1:0]  if_res,
   output logic [12:0] temp_q,
   output logic        sample_valid,
   output logic        above_hi,
   output logic        below_lo,
   output logic        busy,
   output logic        timeout_err,
   output logic [7:0]  overrun
);

   localparam int PW = (PERIOD  > 1) ? $clog2(PERIOD)  : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] KIND_RES = 2'b00;
   localparam logic [1:0] KIND_LO  = 2'b01;
   localparam logic [1:0] KIND_HI  = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE} state_t;
   typedef enum logic [1:0] {OP_SAMPLE, OP_SLEEP, OP_CFG} op_t;

   state_t         state_reg, state_next;
   op_t            op_reg, op_next;
   logic           res_noop_reg;
   logic [1:0]     cfg_kind_reg;
   logic [10:0]    cfg_data_reg;

   logic           if_shutdown_reg;
   logic [1:0]     if_tempWrite_reg;
   logic [10:0]    if_tempInput_reg;
   logic [1:0]     if_res_reg;

   logic [12:0]    temp_q_reg, hi_q_reg, lo_q_reg;
   logic           sample_valid_reg, cfg_ack_reg;
   logic           above_hi_reg, below_lo_reg;
   logic           timeout_err_reg;
   logic [7:0]     overrun_reg;

   logic [PW-1:0]  period_cnt_reg;
   logic           pending_reg;
   logic [TW-1:0]  tmo_cnt_reg;

   logic           issue_start;
   logic           op_done;
   logic           op_timeout;
   logic           waiting;
   logic           period_run;
   logic           period_wrap;
   logic           sample_issue;
   logic           overrun_inc;
   logic [12:0]    bound_value;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         op_reg    <= OP_SAMPLE;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      op_done    = 1'b0;
      op_timeout = 1'b0;
      case (state_reg)
         IDLE: begin
            // cfg_ack_reg masks the request the host is still holding in the ack cycle
            if (if_ready) begin
               if (sleep != if_shutdown_reg) begin
                  op_next    = OP_SLEEP;
                  state_next = ISSUE;
               end else if (cfg_req && !cfg_ack_reg) begin
                  op_next    = OP_CFG;
                  state_next = ISSUE;
               end else if (pending_reg) begin
                  op_next    = OP_SAMPLE;
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (op_reg == OP_CFG && res_noop_reg) begin
               op_done    = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = WAIT_ACCEPT;
            end
         end
         WAIT_ACCEPT: begin
            if (tmo_cnt_reg == TIMEOUT_LAST) begin
               op_timeout = 1'b1;
               state_next = IDLE;
            end else if (!if_ready) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (if_ready) begin
               op_done    = 1'b1;
               state_next = IDLE;
            end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
               op_timeout = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign issue_start  = (state_reg == IDLE) && (state_next == ISSUE);
   assign waiting      = (state_reg == WAIT_ACCEPT) || (state_reg == WAIT_DONE);
   assign sample_issue = (state_reg == ISSUE) && (op_reg == OP_SAMPLE);

   // ----------------------------------------------- operation capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_noop_reg <= 1'b0;
         cfg_kind_reg <= 2'b00;
         cfg_data_reg <= 11'd0;
      end else if (issue_start) begin
         res_noop_reg <= (cfg_kind == KIND_RES) && (cfg_data[1:0] == if_res_reg);
         cfg_kind_reg <= cfg_kind;
         cfg_data_reg <= cfg_data;
      end
   end

   // ------------------------------------------ sensor-interface controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_shutdown_reg  <= 1'b0;
         if_tempWrite_reg <= 2'b00;
         if_tempInput_reg <= 11'd0;
         if_res_reg       <= 2'b11;
      end else if (issue_start) begin
         case (op_next)
            OP_SLEEP: if_shutdown_reg <= sleep;
            OP_CFG: begin
               if (cfg_kind == KIND_RES) begin
                  if_res_reg <= cfg_data[1:0];
               end else begin
                  if_tempWrite_reg <= cfg_kind;
                  if_tempInput_reg <= cfg_data;
               end
            end
            default: ;
         endcase
      end else if (op_timeout || (waiting && !if_ready)) begin
         if_tempWrite_reg <= 2'b00;
      end
   end

   // ------------------------------------------- results and bound compare
   assign bound_value = {cfg_data_reg[10], cfg_data_reg[9:0], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         temp_q_reg       <= 13'd0;
         hi_q_reg         <= 13'h0FFF;
         lo_q_reg         <= 13'h1000;
         sample_valid_reg <= 1'b0;
         cfg_ack_reg      <= 1'b0;
         above_hi_reg     <= 1'b0;
         below_lo_reg     <= 1'b0;
      end else begin
         sample_valid_reg <= op_done && (op_reg == OP_SAMPLE);
         cfg_ack_reg      <= op_done && (op_reg == OP_CFG);
         if (op_done && op_reg == OP_SAMPLE) begin
            temp_q_reg <= {if_tempSign, if_tempVal};
         end
         if (op_done && op_reg == OP_CFG) begin
            if (cfg_kind_reg == KIND_HI) hi_q_reg <= bound_value;
            if (cfg_kind_reg == KIND_LO) lo_q_reg <= bound_value;
         end
         above_hi_reg <= $signed(temp_q_reg) > $signed(hi_q_reg);
         below_lo_reg <= $signed(temp_q_reg) < $signed(lo_q_reg);
      end
   end

   // ------------------------------------------------ sample period timer
   assign period_run  = en && !if_shutdown_reg;
   assign period_wrap = period_run && (period_cnt_reg == PERIOD_LAST);
   // a wrap coinciding with the issue of the pending sample is a fresh request, not an overrun
   assign overrun_inc = period_wrap && pending_reg && !sample_issue;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt_reg <= '0;
         pending_reg    <= 1'b0;
      end else begin
         if (!period_run || period_wrap) begin
            period_cnt_reg <= '0;
         end else begin
            period_cnt_reg <= period_cnt_reg + PW'(1);
         end
         if (period_wrap) begin
            pending_reg <= 1'b1;
         end else if (sample_issue) begin
            pending_reg <= 1'b0;
         end
      end
   end

   // ---------------------------------------------- watchdog and errors
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_reg     <= '0;
         timeout_err_reg <= 1'b0;
         overrun_reg     <= 8'd0;
      end else begin
         if (waiting && !op_timeout) begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
         end else begin
            tmo_cnt_reg <= '0;
         end
         if (op_timeout) begin
            timeout_err_reg <= 1'b1;
         end else if (err_clr) begin
            timeout_err_reg <= 1'b0;
         end
         if (overrun_inc) begin
            if (overrun_reg != 8'hFF) overrun_reg <= overrun_reg + 8'd1;
         end else if (err_clr) begin
            overrun_reg <= 8'd0;
         end
      end
   end

   // ---------------------------------------------------------- outputs
   assign busy         = (state_reg != IDLE);
   assign if_update    = sample_issue;
   assign if_shutdown  = if_shutdown_reg;
   assign if_tempWrite = if_tempWrite_reg;
   assign if_tempInput = if_tempInput_reg;
   assign if_res       = if_res_reg;
   assign temp_q       = temp_q_reg;
   assign sample_valid = sample_valid_reg;
   assign cfg_ack      = cfg_ack_reg;
   assign above_hi     = above_hi_reg;
   assign below_lo     = below_lo_reg;
   assign timeout_err  = timeout_err_reg;
   assign overrun      = overrun_reg;

endmodule
